// File: rtl/reg_xfer_ctrl.sv
// Register-file transfer sequencer: queues {op,src,dst} requests and emits
// registered one-hot bus-drive/capture enables so cpu_bus always has a single settled driver.
module reg_xfer_ctrl #(
    parameter int FIFO_DEPTH    = 2,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [1:0] req_op,
    input  logic [2:0] req_src,
    input  logic [2:0] req_dst,
    output logic [7:0] read_en,
    output logic [7:0] write_en,
    output logic       imm_oe,
    output logic       out_strobe,
    output logic       busy,
    output logic       done,
    output logic       done_err
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int NW = $clog2(FIFO_DEPTH + 1);
    localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    localparam logic [1:0] OP_MOV = 2'b00;
    localparam logic [1:0] OP_IMM = 2'b01;
    localparam logic [1:0] OP_ACC = 2'b10;
    localparam logic [1:0] OP_OUT = 2'b11;

    typedef enum logic [1:0] {IDLE, SETUP, XFER} state_t;
    typedef struct packed {
        logic [1:0] op;
        logic [2:0] src;
        logic [2:0] dst;
    } req_t;

    req_t            mem [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [NW-1:0]   count;
    logic            full, empty, push, pop;
    req_t            head, cur, cur_n;
    state_t          state, state_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [7:0]      rd_n, wr_n;
    logic            imm_n, out_n, done_n, err_n;

    function automatic logic illegal(input req_t r);
        return (r.op == OP_MOV || r.op == OP_IMM) && r.dst == 3'd7;
    endfunction

    function automatic logic noop(input req_t r);
        return r.op == OP_MOV && r.src == r.dst && r.dst != 3'd7;
    endfunction

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full      = (count == NW'(FIFO_DEPTH));
    assign empty     = (count == '0);
    assign req_ready = !full;
    assign push      = req_valid && !full;
    assign head      = mem[rd_ptr];
    assign busy      = (state != IDLE) || !empty;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= req_t'{req_op, req_src, req_dst};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= nxt(wr_ptr);
            if (pop)  rd_ptr <= nxt(rd_ptr);
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    // Next state plus next-cycle output decode; outputs then come straight from flops.
    always_comb begin
        state_n = state;
        cur_n   = cur;
        cnt_n   = cnt;
        pop     = !empty && (state == IDLE || state == XFER);
        case (state)
            SETUP: if (cnt == CW'(SETTLE_CYCLES - 1)) state_n = XFER;
                   else cnt_n = cnt + 1'b1;
            XFER:  state_n = IDLE;
            default: ;
        endcase
        if (pop) begin
            cur_n = head;
            cnt_n = '0;
            // Only real bus transfers need settle time before capture.
            if (illegal(head) || noop(head) || head.op == OP_ACC) state_n = XFER;
            else                                                 state_n = SETUP;
        end

        rd_n  = '0;
        wr_n  = '0;
        imm_n = 1'b0;
        out_n = 1'b0;
        if (state_n != IDLE && !illegal(cur_n) && !noop(cur_n)) begin
            case (cur_n.op)
                OP_MOV: begin
                    rd_n = 8'b1 << cur_n.src;
                    if (state_n == XFER) wr_n = 8'b1 << cur_n.dst;
                end
                OP_IMM: begin
                    imm_n = 1'b1;
                    if (state_n == XFER) wr_n = 8'b1 << cur_n.dst;
                end
                OP_OUT: begin
                    rd_n  = 8'b1 << cur_n.src;
                    out_n = (state_n == XFER);
                end
                default: if (state_n == XFER) wr_n = 8'h80;
            endcase
        end
        done_n = (state == XFER);
        err_n  = (state == XFER) && illegal(cur);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cur        <= '0;
            cnt        <= '0;
            read_en    <= '0;
            write_en   <= '0;
            imm_oe     <= 1'b0;
            out_strobe <= 1'b0;
            done       <= 1'b0;
            done_err   <= 1'b0;
        end else begin
            state      <= state_n;
            cur        <= cur_n;
            cnt        <= cnt_n;
            read_en    <= rd_n;
            write_en   <= wr_n;
            imm_oe     <= imm_n;
            out_strobe <= out_n;
            done       <= done_n;
            done_err   <= err_n;
        end
    end
endmodule

// File: tb/tb_reg_xfer_ctrl.sv
// Scoreboard bench for reg_xfer_ctrl: expected transfer shapes are queued on accept
// and checked by a monitor at every done pulse; directed checks cover reset and latency.
module tb_reg_xfer_ctrl;
    logic       clk = 1'b0;
    logic       reset;
    logic       req_valid;
    logic       req_ready;
    logic [1:0] req_op;
    logic [2:0] req_src, req_dst;
    logic [7:0] read_en, write_en;
    logic       imm_oe, out_strobe, busy, done, done_err;

    int checks = 0;
    int errors = 0;
    int ndone  = 0;
    logic saw_full = 1'b0;

    typedef struct {
        logic       err;
        logic       hs;    // check read_en/imm_oe on the cycle before XFER
        logic [7:0] srd;
        logic       simm;
        logic [7:0] xrd;
        logic [7:0] xwr;
        logic       ximm;
        logic       xout;
    } exp_t;

    exp_t expq[$];
    exp_t cur_exp;

    reg_xfer_ctrl #(.FIFO_DEPTH(2), .SETTLE_CYCLES(1)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_src(req_src), .req_dst(req_dst),
        .read_en(read_en), .write_en(write_en), .imm_oe(imm_oe), .out_strobe(out_strobe),
        .busy(busy), .done(done), .done_err(done_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, want, $time);
        end
    endtask

    function automatic exp_t mk(input logic err, input logic hs, input logic [7:0] srd,
                                input logic simm, input logic [7:0] xrd, input logic [7:0] xwr,
                                input logic ximm, input logic xout);
        exp_t e;
        e.err = err; e.hs = hs; e.srd = srd; e.simm = simm;
        e.xrd = xrd; e.xwr = xwr; e.ximm = ximm; e.xout = xout;
        return e;
    endfunction

    // Accept capture: expected item enters the scoreboard on the accepting edge.
    always @(posedge clk) begin
        if (!reset) begin
            if (!req_ready) saw_full = 1'b1;
            if (req_valid && req_ready) expq.push_back(cur_exp);
        end
    end

    // Monitor: invariants every cycle, scoreboard compare on each done pulse.
    logic [7:0] p1_rd, p1_wr, p2_rd;
    logic       p1_imm, p1_out, p2_imm;
    always @(negedge clk) begin
        if (!reset) begin
            chk("onehot_drive", 32'($countones(read_en) + 32'(imm_oe) <= 1), 32'd1);
            chk("onehot_write", 32'($countones(write_en) <= 1), 32'd1);
            if (done) begin
                ndone++;
                if (expq.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = expq.pop_front();
                    chk("done_err", 32'(done_err), 32'(e.err));
                    chk("xfer_read_en", 32'(p1_rd), 32'(e.xrd));
                    chk("xfer_write_en", 32'(p1_wr), 32'(e.xwr));
                    chk("xfer_imm_oe", 32'(p1_imm), 32'(e.ximm));
                    chk("xfer_out_strobe", 32'(p1_out), 32'(e.xout));
                    if (e.hs) begin
                        chk("setup_read_en", 32'(p2_rd), 32'(e.srd));
                        chk("setup_imm_oe", 32'(p2_imm), 32'(e.simm));
                    end
                end
            end
            p2_rd = p1_rd; p2_imm = p1_imm;
            p1_rd = read_en; p1_wr = write_en; p1_imm = imm_oe; p1_out = out_strobe;
        end
    end

    // Returns #1 after the accepting edge.
    task automatic send(input logic [1:0] op, input logic [2:0] src, input logic [2:0] dst,
                        input exp_t e);
        bit ok = 1'b0;
        req_op = op; req_src = src; req_dst = dst; cur_exp = e; req_valid = 1'b1;
        for (int i = 0; i < 200 && !ok; i++) begin
            if (req_ready) ok = 1'b1;
            @(posedge clk); #1;
        end
        if (!ok) chk("accept_timeout", 32'd1, 32'd0);
        req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (!busy && !done) ok = 1'b1;
        end
        if (!ok) chk("idle_timeout", 32'd1, 32'd0);
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        reset = 1'b1; req_valid = 1'b0; req_op = '0; req_src = '0; req_dst = '0;
        cur_exp = mk(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("rst_read_en", 32'(read_en), 32'h0);
        chk("rst_write_en", 32'(write_en), 32'h0);
        chk("rst_flags", {28'd0, imm_oe, out_strobe, done, done_err}, 32'h0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd1);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // MOV R2->R5 cycle-exact latency
        send(2'b00, 3'd2, 3'd5, mk(0, 1, 8'h04, 0, 8'h04, 8'h20, 0, 0));
        @(negedge clk); chk("lat_e0_read", 32'(read_en), 32'h00);
        chk("lat_e0_busy", 32'(busy), 32'd1);
        @(negedge clk); chk("lat_e1_read", 32'(read_en), 32'h04);
        chk("lat_e1_write", 32'(write_en), 32'h00);
        @(negedge clk); chk("lat_e2_read", 32'(read_en), 32'h04);
        chk("lat_e2_write", 32'(write_en), 32'h20);
        @(negedge clk); chk("lat_e3_done", 32'(done), 32'd1);
        chk("lat_e3_enables", {16'd0, read_en, write_en}, 32'h0);
        wait_idle();

        // IMM dst=3 then ACC_WR back-to-back; ACC_WR's prior cycle is the IMM XFER
        send(2'b01, 3'd0, 3'd3, mk(0, 1, 8'h00, 1, 8'h00, 8'h08, 1, 0));
        send(2'b10, 3'd0, 3'd0, mk(0, 1, 8'h00, 1, 8'h00, 8'h80, 0, 0));
        wait_idle();

        // illegal dst=7, then no-op R4->R4
        send(2'b00, 3'd2, 3'd7, mk(1, 1, 8'h00, 0, 8'h00, 8'h00, 0, 0));
        wait_idle();
        send(2'b00, 3'd4, 3'd4, mk(0, 1, 8'h00, 0, 8'h00, 8'h00, 0, 0));
        wait_idle();
        send(2'b01, 3'd1, 3'd7, mk(1, 1, 8'h00, 0, 8'h00, 8'h00, 0, 0));
        wait_idle();

        // OUT R7 and OUT R0
        send(2'b11, 3'd7, 3'd0, mk(0, 1, 8'h80, 0, 8'h80, 8'h00, 0, 1));
        send(2'b11, 3'd0, 3'd5, mk(0, 1, 8'h01, 0, 8'h01, 8'h00, 0, 1));
        wait_idle();

        // four MOVs offered continuously into a 2-deep queue
        saw_full = 1'b0;
        d0 = ndone;
        send(2'b00, 3'd0, 3'd1, mk(0, 1, 8'h01, 0, 8'h01, 8'h02, 0, 0));
        send(2'b00, 3'd1, 3'd2, mk(0, 1, 8'h02, 0, 8'h02, 8'h04, 0, 0));
        send(2'b00, 3'd2, 3'd3, mk(0, 1, 8'h04, 0, 8'h04, 8'h08, 0, 0));
        send(2'b00, 3'd6, 3'd0, mk(0, 1, 8'h40, 0, 8'h40, 8'h01, 0, 0));
        wait_idle();
        chk("full_seen", 32'(saw_full), 32'd1);
        chk("four_dones", 32'(ndone - d0), 32'd4);
        chk("queue_drained", 32'(expq.size()), 32'd0);

        // three ACC_WR back-to-back
        for (int i = 0; i < 3; i++) send(2'b10, 3'd3, 3'd1, mk(0, 1, 8'h00, 0, 8'h00, 8'h80, 0, 0));
        wait_idle();

        // reset during XFER of MOV R1->R6 with one more queued
        send(2'b00, 3'd1, 3'd6, mk(0, 1, 8'h02, 0, 8'h02, 8'h40, 0, 0));
        send(2'b00, 3'd2, 3'd3, mk(0, 1, 8'h04, 0, 8'h04, 8'h08, 0, 0));
        @(posedge clk); #2;
        chk("pre_rst_xfer_write", 32'(write_en), 32'h40);
        d0 = ndone;
        reset = 1'b1;
        #1;
        chk("rst_mid_read", 32'(read_en), 32'h0);
        chk("rst_mid_write", 32'(write_en), 32'h0);
        expq.delete();
        @(posedge clk); #1 reset = 1'b0;
        repeat (5) @(negedge clk);
        chk("post_rst_busy", 32'(busy), 32'd0);
        chk("post_rst_no_done", 32'(ndone - d0), 32'd0);

        // normal traffic after reset
        send(2'b00, 3'd5, 3'd2, mk(0, 1, 8'h20, 0, 8'h20, 8'h04, 0, 0));
        wait_idle();
        chk("final_queue_empty", 32'(expq.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
